// File: rtl/gray_pkg.sv
// Shared constants and Gray-code helpers for the gray counter and its consumers.
package gray_pkg;

  localparam int unsigned GRAY_WIDTH_DEF = 4;
  localparam int unsigned GRAY_WIDTH_MAX = 16;

  // Binary to Gray: each output bit is the XOR of adjacent binary bits.
  function automatic logic [GRAY_WIDTH_MAX-1:0] bin2gray(input logic [GRAY_WIDTH_MAX-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Gray to binary: prefix XOR from the MSB down, same as the downstream decoder.
  function automatic logic [GRAY_WIDTH_MAX-1:0] gray2bin(input logic [GRAY_WIDTH_MAX-1:0] gray);
    logic [GRAY_WIDTH_MAX-1:0] bin;
    bin[GRAY_WIDTH_MAX-1] = gray[GRAY_WIDTH_MAX-1];
    for (int i = GRAY_WIDTH_MAX - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_encode.sv
// Combinational WIDTH-bit binary to Gray encoder.
module gray_encode
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = GRAY_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray_c
);

  // Zero-extend into the package helper and keep only the live bits.
  logic [GRAY_WIDTH_MAX-1:0] gray_full;

  always_comb begin
    gray_full = bin2gray(GRAY_WIDTH_MAX'(bin));
    gray_c    = gray_full[WIDTH-1:0];
  end

endmodule

// File: rtl/gray_counter.sv
// Up/down counter with registered Gray-coded output and terminal-count flag.
// Optional build macro: GRAY_COUNTER_SAT_EN (saturate at the ends instead of
// wrapping; tc then stays high on every blocked count cycle).
module gray_counter
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = GRAY_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] gray,
  output logic             tc
);

  localparam logic [WIDTH-1:0] BIN_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] BIN_MIN = '0;

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] bin_d;
  logic [WIDTH-1:0] gray_d;
  logic             tc_d;
  logic             at_end;

  // Next binary count and terminal-count flag; load beats count, count beats hold.
  always_comb begin
    bin_d  = bin_q;
    tc_d   = 1'b0;
    at_end = up_dn ? (bin_q == BIN_MAX) : (bin_q == BIN_MIN);
    if (load) begin
      bin_d = load_val;
    end else if (en) begin
      tc_d = at_end;
`ifdef GRAY_COUNTER_SAT_EN
      if (!at_end) begin
        bin_d = up_dn ? bin_q + WIDTH'(1) : bin_q - WIDTH'(1);
      end
`else
      bin_d = up_dn ? bin_q + WIDTH'(1) : bin_q - WIDTH'(1);
`endif
    end
  end

  // Encode the next count so the Gray output comes straight off flops.
  gray_encode #(
    .WIDTH (WIDTH)
  ) u_encode (
    .bin    (bin_d),
    .gray_c (gray_d)
  );

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q <= '0;
      gray  <= '0;
      tc    <= 1'b0;
    end else begin
      bin_q <= bin_d;
      gray  <= gray_d;
      tc    <= tc_d;
    end
  end

endmodule
